// File: rtl/chained_add_pkg.sv
// Shared arithmetic for the chained adder pipeline: width-generic add with carry-out.
// Saturating sums are built when CHAINED_ADD_PIPE_SAT_EN is defined; otherwise sums wrap.
package chained_add_pkg;

   localparam int MAX_WIDTH = 64;

   // Returns {carry, sum}. The operands must be zero above `width`. Zero-extending
   // them to MAX_WIDTH lets one function serve every parameterisation of WIDTH.
   function automatic logic [MAX_WIDTH:0] add_ovf(input logic [MAX_WIDTH-1:0] a,
                                                  input logic [MAX_WIDTH-1:0] b,
                                                  input int unsigned        width);
      logic [MAX_WIDTH:0] full;
      logic [MAX_WIDTH:0] mask;
      logic               carry;
      full  = {1'b0, a} + {1'b0, b};
      mask  = {(MAX_WIDTH + 1){1'b1}} >> (MAX_WIDTH + 1 - width);
      carry = |(full & ~mask);
      full  = full & mask;
`ifdef CHAINED_ADD_PIPE_SAT_EN
      if (carry) begin
         full = mask;
      end
`endif
      return {carry, full[MAX_WIDTH-1:0]};
   endfunction

endpackage

// File: rtl/chained_add_stage.sv
// One registered stage of the chained adder: x <= a + upstream x, ovf accumulates carries.
// The stage loads whenever it is empty or its downstream neighbour can take its beat.
module chained_add_stage
   import chained_add_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_a,
   input  logic [WIDTH-1:0] up_x,
   input  logic             up_ovf,
   input  logic             down_ready,
   output logic             valid,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] x,
   output logic             ovf
);

   typedef struct packed {
      logic             valid;
      logic             ovf;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] x;
   } stage_t;

   stage_t             q;
   stage_t             d;
   logic               load;
   logic [MAX_WIDTH:0] add_res;
   logic               unused_add_bits;

   assign add_res         = add_ovf(MAX_WIDTH'(up_a), MAX_WIDTH'(up_x), WIDTH);
   assign unused_add_bits = ^(add_res >> WIDTH);
   assign load            = !q.valid || down_ready;

   // Payload only changes when a valid beat arrives, so a drained stage keeps its last sum.
   always_comb begin
      d = q;
      if (load) begin
         d.valid = up_valid;
         if (up_valid) begin
            d.a   = up_a;
            d.x   = add_res[WIDTH-1:0];
            d.ovf = up_ovf | add_res[MAX_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

   assign valid = q.valid;
   assign a     = q.a;
   assign x     = q.x;
   assign ovf   = q.ovf;

endmodule

// File: rtl/chained_add_pipe.sv
// STAGES chained adder stages with valid/ready flow control: out_x = STAGES*a + b.
// Define CHAINED_ADD_PIPE_SAT_EN for saturating stages; the default build wraps.
module chained_add_pipe
   import chained_add_pkg::*;
#(
   parameter int  WIDTH  = 32,
   parameter int  STAGES = 2,
   localparam int OCC_W  = $clog2(STAGES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic             out_ovf,
   output logic             ovf_sticky,
   input  logic             ovf_clr,
   output logic [OCC_W-1:0] occupancy
);

   logic [STAGES-1:0] stage_valid;
   logic [STAGES-1:0] stage_ovf;
   logic [WIDTH-1:0]  stage_a [STAGES];
   logic [WIDTH-1:0]  stage_x [STAGES];
   logic [STAGES:0]   stage_ready;
   logic              unused_tail_a;

   // Ready ripples backwards from the consumer; a stage can accept if it is empty
   // or everything downstream of it is moving.
   always_comb begin
      stage_ready         = '0;
      stage_ready[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         stage_ready[k] = !stage_valid[k] || stage_ready[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_a;
      logic [WIDTH-1:0] up_x;
      logic             up_ovf;

      if (k == 0) begin : g_head
         assign up_valid = in_valid;
         assign up_a     = in_a;
         assign up_x     = in_b;
         assign up_ovf   = 1'b0;
      end else begin : g_body
         assign up_valid = stage_valid[k-1];
         assign up_a     = stage_a[k-1];
         assign up_x     = stage_x[k-1];
         assign up_ovf   = stage_ovf[k-1];
      end

      chained_add_stage #(.WIDTH(WIDTH)) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .up_valid   (up_valid),
         .up_a       (up_a),
         .up_x       (up_x),
         .up_ovf     (up_ovf),
         .down_ready (stage_ready[k+1]),
         .valid      (stage_valid[k]),
         .a          (stage_a[k]),
         .x          (stage_x[k]),
         .ovf        (stage_ovf[k])
      );
   end

   assign unused_tail_a = ^stage_a[STAGES-1];

   assign in_ready  = stage_ready[0];
   assign out_valid = stage_valid[STAGES-1];
   assign out_x     = stage_x[STAGES-1];
   assign out_ovf   = stage_ovf[STAGES-1];

   always_comb begin
      occupancy = '0;
      for (int k = 0; k < STAGES; k++) begin
         occupancy = occupancy + OCC_W'(stage_valid[k]);
      end
   end

   // A retiring overflow beat beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (out_valid && out_ready && out_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_chained_add_pipe.sv
// Directed and randomised checks of chained_add_pipe at 32b/2 stages and 8b/4 stages.
// Expected values follow CHAINED_ADD_PIPE_SAT_EN when the build defines it.
module tb_chained_add_pipe;

   localparam int W  = 32;
   localparam int S  = 2;
   localparam int W4 = 8;
   localparam int S4 = 4;
   localparam int N4 = 300;

`ifdef CHAINED_ADD_PIPE_SAT_EN
   localparam logic [31:0] OVF_X = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] OVF_X = 32'h0000_0000;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_x;
      logic        exp_ovf;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_x;
   logic          out_ovf;
   logic          ovf_sticky;
   logic          ovf_clr;
   logic [1:0]    occupancy;

   logic          in_valid4;
   logic          in_ready4;
   logic [W4-1:0] in_a4;
   logic [W4-1:0] in_b4;
   logic          out_valid4;
   logic          out_ready4;
   logic [W4-1:0] out_x4;
   logic          out_ovf4;
   logic          ovf_sticky4;
   logic          ovf_clr4;
   logic [2:0]    occupancy4;

   int            n_vectors;
   int            n_miscompares;
   vec_t          vecs [8];
   logic [31:0]   exp_q [$];
   logic [8:0]    exp_q4 [$];
   logic [8:0]    exp_beat4;
   int            sent;
   int            got;
   int            sent4;
   int            got4;
   logic          holding;

   chained_add_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_x      (out_x),
      .out_ovf    (out_ovf),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr),
      .occupancy  (occupancy)
   );

   chained_add_pipe #(.WIDTH(W4), .STAGES(S4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid4),
      .in_ready   (in_ready4),
      .in_a       (in_a4),
      .in_b       (in_b4),
      .out_valid  (out_valid4),
      .out_ready  (out_ready4),
      .out_x      (out_x4),
      .out_ovf    (out_ovf4),
      .ovf_sticky (ovf_sticky4),
      .ovf_clr    (ovf_clr4),
      .occupancy  (occupancy4)
   );

   // One comparison: bump the counters and report any difference.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Present one beat to the 32b pipe for a single cycle; returns at the next negedge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      #1;
      checkOutput("in_ready_idle", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Reference for the 8b/4-stage pipe: {ovf, x}.
   function automatic logic [8:0] model4(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      logic [7:0] s;
      logic       ovf;
`ifdef CHAINED_ADD_PIPE_SAT_EN
      s   = b;
      ovf = 1'b0;
      for (int k = 0; k < S4; k++) begin
         sum = {1'b0, a} + {1'b0, s};
         ovf = ovf | sum[8];
         s   = sum[8] ? 8'hFF : sum[7:0];
      end
`else
      int total;
      total = 4 * int'(a) + int'(b);
      s     = 8'(total);
      ovf   = (total > 255);
      sum   = '0;
`endif
      return {ovf, s};
   endfunction

   initial begin
      n_vectors     = 0;
      n_miscompares = 0;
      vecs[0] = '{32'd3,          32'd5,          32'd11,         1'b0};
      vecs[1] = '{32'd0,          32'd0,          32'd0,          1'b0};
      vecs[2] = '{32'd100,        32'd7,          32'd207,        1'b0};
      vecs[3] = '{32'hFFFF_FFFF,  32'd2,          OVF_X,          1'b1};
      vecs[4] = '{32'h8000_0000,  32'd0,          OVF_X,          1'b1};
      vecs[5] = '{32'h7FFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
      vecs[6] = '{32'h1234_5678,  32'h1111_1111,  32'h3579_BE01,  1'b0};
      vecs[7] = '{32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0};

      rst_n = 1'b0;
      in_valid = 1'b0;  in_a = '0;  in_b = '0;  out_ready = 1'b1;  ovf_clr = 1'b0;
      in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; out_ready4 = 1'b1; ovf_clr4 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_x", out_x, 0);
      checkOutput("rst_out_ovf", out_ovf, 0);
      checkOutput("rst_sticky", ovf_sticky, 0);
      checkOutput("rst_occupancy", occupancy, 0);
      checkOutput("rst_in_ready", in_ready, 1);

      // Table: each vector goes through alone, then the sticky flag is checked and cleared.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b);
         checkOutput("lat_early_valid", out_valid, 0);
         @(negedge clk);
         checkOutput("lat_out_valid", out_valid, 1);
         checkOutput("vec_out_x", out_x, vecs[i].exp_x);
         checkOutput("vec_out_ovf", out_ovf, vecs[i].exp_ovf);
         @(negedge clk);
         checkOutput("drain_out_valid", out_valid, 0);
         checkOutput("drain_out_x_held", out_x, vecs[i].exp_x);
         checkOutput("drain_occupancy", occupancy, 0);
         checkOutput("vec_sticky", ovf_sticky, vecs[i].exp_ovf);
         ovf_clr = 1'b1;
         @(negedge clk);
         ovf_clr = 1'b0;
         checkOutput("clr_sticky", ovf_sticky, 0);
      end

      // Set wins over clear when an overflow beat retires in the same cycle.
      applyStimulus(32'hFFFF_FFFF, 32'd2);
      @(negedge clk);
      checkOutput("setwin_out_ovf", out_ovf, 1);
      ovf_clr = 1'b1;
      @(negedge clk);
      checkOutput("setwin_sticky", ovf_sticky, 1);
      @(negedge clk);
      ovf_clr = 1'b0;
      checkOutput("setwin_cleared", ovf_sticky, 0);

      // Backpressure: consumer stalls for 4 cycles while a=1..6 streams in.
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 4);
         in_valid  = (sent < 6);
         in_a      = 32'(sent + 1);
         in_b      = '0;
         #1;
         if (cyc == 2 || cyc == 3 || cyc == 4) begin
            checkOutput("bp_occupancy", occupancy, 2);
            checkOutput("bp_in_ready", in_ready, (cyc == 4) ? 1 : 0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("bp_extra_beat", 1, 0);
            end else begin
               checkOutput("bp_out_x", out_x, exp_q.pop_front());
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(32'(2 * (sent + 1)));
            sent++;
         end
      end
      in_valid = 1'b0;
      checkOutput("bp_beats_out", got, 6);
      @(negedge clk);
      checkOutput("bp_empty", occupancy, 0);

      // Reset mid-flight: sticky set, two beats stalled in the pipe, then a one-cycle reset.
      applyStimulus(32'hFFFF_FFFF, 32'd2);
      @(negedge clk);
      @(negedge clk);
      checkOutput("mid_pre_sticky", ovf_sticky, 1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = 32'd5;
      in_b      = 32'd0;
      @(negedge clk);
      in_a      = 32'd6;
      @(negedge clk);
      in_valid  = 1'b0;
      checkOutput("mid_pre_occupancy", occupancy, 2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("mid_out_valid", out_valid, 0);
      checkOutput("mid_occupancy", occupancy, 0);
      checkOutput("mid_sticky", ovf_sticky, 0);
      checkOutput("mid_in_ready", in_ready, 1);
      checkOutput("mid_out_x", out_x, 0);
      out_ready = 1'b1;

      // 8b/4-stage: latency of exactly four cycles.
      @(negedge clk);
      in_valid4 = 1'b1;
      in_a4     = 8'd10;
      in_b4     = 8'd7;
      @(negedge clk);
      in_valid4 = 1'b0;
      for (int i = 1; i < S4; i++) begin
         checkOutput("s4_lat_early", out_valid4, 0);
         @(negedge clk);
      end
      checkOutput("s4_lat_valid", out_valid4, 1);
      checkOutput("s4_out_x", out_x4, 47);
      checkOutput("s4_out_ovf", out_ovf4, 0);

      // 8b/4-stage: random valid/ready traffic against a scoreboard.
      sent4   = 0;
      got4    = 0;
      holding = 1'b0;
      for (int cyc = 0; cyc < 5000 && got4 < N4; cyc++) begin
         @(negedge clk);
         if (!holding && sent4 < N4 && $urandom_range(0, 3) != 0) begin
            holding = 1'b1;
            in_a4   = 8'($urandom);
            in_b4   = 8'($urandom);
         end
         in_valid4  = holding;
         out_ready4 = ($urandom_range(0, 3) != 0);
         #1;
         checkOutput("s4_rand_occupancy", occupancy4, 64'(sent4 - got4));
         if (out_valid4 && out_ready4) begin
            if (exp_q4.size() == 0) begin
               checkOutput("s4_rand_extra_beat", 1, 0);
            end else begin
               exp_beat4 = exp_q4.pop_front();
               checkOutput("s4_rand_out_x", out_x4, exp_beat4[7:0]);
               checkOutput("s4_rand_out_ovf", out_ovf4, exp_beat4[8]);
            end
            got4++;
         end
         if (in_valid4 && in_ready4) begin
            exp_q4.push_back(model4(in_a4, in_b4));
            sent4++;
            holding = 1'b0;
         end
      end
      in_valid4 = 1'b0;
      checkOutput("s4_rand_beats_out", got4, N4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
